// File: rtl/preamble_gen.sv
// preamble_gen: QPSK preamble inserter on the inband TX path.
// Optional guard interval after the chips: define PREAMBLE_GUARD_EN.
module preamble_gen #(
  parameter int MAX_WORDS = 8,
  parameter int GUARD_LEN = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        txstrobe,
  input  logic [15:0] in_real,
  input  logic [15:0] in_img,
  input  logic [31:0] cdata,
  input  logic [2:0]  cstate,
  input  logic        cwrite,
  input  logic        csel,
  input  logic        start,
  output logic [15:0] tx_real,
  output logic [15:0] tx_img,
  output logic        tx_valid,
  output logic        in_hold,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GUARD
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  k_q, k_d;
  logic [31:0] word_q, word_d;
  logic [14:0] amp_q, amp_d;
  logic [6:0]  len_q, len_d;
  logic        fin_q, fin_d;
  logic [15:0] txr_q, txr_d;
  logic [15:0] txi_q, txi_d;
  logic        vld_q, vld_d;
  logic        done_q, done_d;
  logic [31:0] mem [MAX_WORDS];

`ifdef PREAMBLE_GUARD_EN
  localparam int GW = (GUARD_LEN > 1) ? $clog2(GUARD_LEN) : 1;
  logic [GW-1:0] gcnt_q, gcnt_d;
`endif

  logic [1:0]  sym;
  logic [15:0] amp_p;
  logic [15:0] amp_n;
  logic [15:0] chip_r;
  logic [15:0] chip_i;

  assign busy     = (state_q != IDLE);
  assign in_hold  = busy;
  assign tx_real  = txr_q;
  assign tx_img   = txi_q;
  assign tx_valid = vld_q;
  assign done     = done_q;

  assign sym   = {word_q[{1'b1, k_q[3:0]}],
                  word_q[{1'b0, k_q[3:0]}]};
  assign amp_p = {1'b0, amp_q};
  assign amp_n = -amp_p;

  // Coefficient RAM; locked while a sequence is running
  always_ff @(posedge clk) begin
    if (cwrite && !csel && !busy)
      mem[cstate] <= cdata;
  end

  // Map the current chip pair to a QPSK symbol
  always_comb begin
    chip_r = '0;
    chip_i = '0;
    case (sym)
      2'b00:   chip_r = amp_p;
      2'b01:   chip_i = amp_n;
      2'b10:   chip_i = amp_p;
      default: chip_r = amp_n;
    endcase
  end

  // Next-state, word prefetch, config and output sample
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    word_d  = word_q;
    amp_d   = amp_q;
    len_d   = len_q;
    fin_d   = 1'b0;
    txr_d   = txr_q;
    txi_d   = txi_q;
    vld_d   = 1'b0;
    done_d  = 1'b0;
`ifdef PREAMBLE_GUARD_EN
    gcnt_d  = gcnt_q;
`endif
    if (cwrite && csel && !busy) begin
      amp_d = cdata[30:16];
      len_d = cdata[6:0];
    end
    unique case (state_q)
      IDLE: begin
        if (txstrobe) begin
          txr_d = in_real;
          txi_d = in_img;
          vld_d = 1'b1;
        end
        if (start) begin
          state_d = SEND;
          k_d     = '0;
          word_d  = mem[3'd0];
        end
      end
      SEND: begin
        if (fin_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (txstrobe) begin
          txr_d = chip_r;
          txi_d = chip_i;
          vld_d = 1'b1;
          k_d   = k_q + 7'd1;
          if (k_q[3:0] == 4'hF)
            word_d = mem[k_q[6:4] + 3'd1];
          if (k_q == len_q) begin
`ifdef PREAMBLE_GUARD_EN
            state_d = GUARD;
            gcnt_d  = '0;
`else
            fin_d   = 1'b1;
`endif
          end
        end
      end
      GUARD: begin
`ifdef PREAMBLE_GUARD_EN
        if (fin_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (txstrobe) begin
          txr_d  = '0;
          txi_d  = '0;
          vld_d  = 1'b1;
          gcnt_d = gcnt_q + 1'b1;
          if (gcnt_q == GW'(GUARD_LEN - 1))
            fin_d = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      word_q  <= '0;
      amp_q   <= 15'h0400;
      len_q   <= 7'd15;
      fin_q   <= 1'b0;
      txr_q   <= '0;
      txi_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef PREAMBLE_GUARD_EN
      gcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      word_q  <= word_d;
      amp_q   <= amp_d;
      len_q   <= len_d;
      fin_q   <= fin_d;
      txr_q   <= txr_d;
      txi_q   <= txi_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
`ifdef PREAMBLE_GUARD_EN
      gcnt_q  <= gcnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_preamble_gen.sv
// tb_preamble_gen: directed checks of the preamble inserter.
// Guard expectations follow PREAMBLE_GUARD_EN.
module tb_preamble_gen;

  localparam int GL = 4;
`ifdef PREAMBLE_GUARD_EN
  localparam bit CHIP_DONE = 1'b0;
`else
  localparam bit CHIP_DONE = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        txstrobe;
  logic [15:0] in_real;
  logic [15:0] in_img;
  logic [31:0] cdata;
  logic [2:0]  cstate;
  logic        cwrite;
  logic        csel;
  logic        start;
  logic [15:0] tx_real;
  logic [15:0] tx_img;
  logic        tx_valid;
  logic        in_hold;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] words [8] = '{
    32'hA5C3_3C5A, 32'h0F0F_00FF, 32'h1234_8765, 32'hFFFF_0000,
    32'h0000_FFFF, 32'h6996_9669, 32'hC0DE_BEEF, 32'h8001_7FFE
  };

  // word 0x0003_0005, amp 0x1000: pairs {r,i} = 11, 10, 01, 00
  logic [31:0] map_exp [4] = '{
    32'hF000_0000, 32'h0000_1000, 32'h0000_F000, 32'h1000_0000
  };

  preamble_gen #(
    .MAX_WORDS(8),
    .GUARD_LEN(GL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .txstrobe (txstrobe),
    .in_real  (in_real),
    .in_img   (in_img),
    .cdata    (cdata),
    .cstate   (cstate),
    .cwrite   (cwrite),
    .csel     (csel),
    .start    (start),
    .tx_real  (tx_real),
    .tx_img   (tx_img),
    .tx_valid (tx_valid),
    .in_hold  (in_hold),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_chip(input logic [31:0] w,
                                           input int k,
                                           input logic [14:0] amp);
    logic [15:0] a;
    logic [15:0] n;
    logic [1:0]  s;
    a = {1'b0, amp};
    n = -a;
    s = {w[16 + (k % 16)], w[k % 16]};
    case (s)
      2'b00:   return {a, 16'h0000};
      2'b01:   return {16'h0000, n};
      2'b10:   return {16'h0000, a};
      default: return {n, 16'h0000};
    endcase
  endfunction

  task automatic wr_coef(input logic [2:0] a, input logic [31:0] d);
    cstate = a;
    cdata  = d;
    csel   = 1'b0;
    cwrite = 1'b1;
    tick();
    cwrite = 1'b0;
  endtask

  task automatic wr_cfg(input logic [15:0] a, input logic [6:0] l);
    cdata  = {a, 9'd0, l};
    csel   = 1'b1;
    cwrite = 1'b1;
    tick();
    cwrite = 1'b0;
    csel   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    check("hold_rise", 32'(in_hold), 32'd1);
  endtask

  task automatic strobe(output logic [15:0] r, output logic [15:0] i,
                        output logic v, output logic d, output logic b);
    txstrobe = 1'b1;
    tick();
    r = tx_real;
    i = tx_img;
    v = tx_valid;
    txstrobe = 1'b0;
    tick();
    d = done;
    b = busy;
  endtask

  task automatic chip_step(input string tag, input logic [15:0] er,
                           input logic [15:0] ei, input logic last);
    logic [15:0] r;
    logic [15:0] i;
    logic v, d, b;
    strobe(r, i, v, d, b);
    check({tag, "_re"}, 32'(r), 32'(er));
    check({tag, "_im"}, 32'(i), 32'(ei));
    check({tag, "_valid"}, 32'(v), 32'd1);
    check({tag, "_done"}, 32'(d), 32'(last));
    check({tag, "_busy"}, 32'(b), 32'(!last));
  endtask

  task automatic expect_tail(input string tag);
`ifdef PREAMBLE_GUARD_EN
    for (int g = 0; g < GL; g++)
      chip_step({tag, "_guard"}, 16'h0, 16'h0, g == GL - 1);
`endif
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic expect_seq(input string tag, input int n,
                            input logic [14:0] amp);
    for (int k = 0; k < n; k++) begin
      logic [31:0] e;
      e = exp_chip(words[k / 16], k, amp);
      chip_step(tag, e[31:16], e[15:0], (k == n - 1) && CHIP_DONE);
    end
    expect_tail(tag);
  endtask

  initial begin
    logic [15:0] r;
    logic [15:0] i;
    logic v, d, b;
    logic [31:0] e;
    reset    = 1'b0;
    txstrobe = 1'b0;
    start    = 1'b0;
    cwrite   = 1'b0;
    csel     = 1'b0;
    cdata    = '0;
    cstate   = '0;
    in_real  = 16'h1234;
    in_img   = 16'hFEDC;
    tick();
    tick();
    check("rst_tx", {tx_real, tx_img}, 32'h0);
    check("rst_flags", 32'({tx_valid, in_hold, busy, done}), 32'h0);
    reset = 1'b1;
    tick();

    for (int w = 0; w < 8; w++)
      wr_coef(3'(w), words[w]);

    do_start();
    for (int k = 0; k < 2; k++) begin
      e = exp_chip(words[0], k, 15'h0400);
      chip_step("pre_rst", e[31:16], e[15:0], 1'b0);
    end
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_tx", {tx_real, tx_img}, 32'h0);
    check("async_rst_flags",
          32'({tx_valid, in_hold, busy, done}), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);

    do_start();
    expect_seq("dflt", 16, 15'h0400);

    strobe(r, i, v, d, b);
    check("pass_re", 32'(r), 32'h1234);
    check("pass_im", 32'(i), 32'hFEDC);
    check("pass_valid", 32'(v), 32'd1);
    check("pass_valid_pulse", 32'(tx_valid), 32'd0);
    check("pass_idle", 32'(b), 32'd0);

    wr_coef(3'd0, 32'h0003_0005);
    wr_cfg(16'h1000, 7'd3);
    do_start();
    for (int k = 0; k < 4; k++)
      chip_step("map", map_exp[k][31:16], map_exp[k][15:0],
                (k == 3) && CHIP_DONE);
    expect_tail("map");

    do_start();
    for (int k = 0; k < 2; k++)
      chip_step("lock", map_exp[k][31:16], map_exp[k][15:0], 1'b0);
    wr_coef(3'd0, 32'hFFFF_FFFF);
    wr_cfg(16'h7FFF, 7'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k < 4; k++)
      chip_step("lock", map_exp[k][31:16], map_exp[k][15:0],
                (k == 3) && CHIP_DONE);
    expect_tail("lock");
    check("lock_no_restart", 32'(busy), 32'd0);

    do_start();
    for (int k = 0; k < 4; k++)
      chip_step("lock_rerun", map_exp[k][31:16], map_exp[k][15:0],
                (k == 3) && CHIP_DONE);
    expect_tail("lock_rerun");

    wr_cfg(16'h1000, 7'd0);
    do_start();
    chip_step("len1", 16'hF000, 16'h0000, CHIP_DONE);
    expect_tail("len1");

    wr_coef(3'd0, words[0]);
    wr_cfg(16'h9234, 7'd127);
    do_start();
    expect_seq("full", 128, 15'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
